hazard_scan: RTL

Parametrised player-versus-object collision monitor for the game top level. It scans up to `N_OBJ` object bounding boxes sequentially, one object per clock, against the player box. It then commits a per-object hit mask and runs a saturating persistence counter. Once `HIT_CNT` consecutive scans report a hit, it raises a sticky `over` flag for the game state FSM. It replaces the fixed 16-barrel combinational compare and the 128-bit collision shift register with a single time-multiplexed comparator and a counter.

---
 rtl/hazard_scan.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_scan.sv
// Time-multiplexed player-versus-object collision monitor with hit persistence counter.
// Optional forbidden-zone loss condition enabled by defining HAZARD_ZONE_EN.
module hazard_scan #(
  parameter int unsigned N_OBJ    = 16,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned PLAYER_W = 34,
  parameter int unsigned PLAYER_H = 36,
  parameter int unsigned HIT_CNT  = 128
`ifdef HAZARD_ZONE_EN
  ,
  parameter int unsigned ZONE_X   = 183,
  parameter int unsigned ZONE_Y   = 114
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [XW-1:0]            player_x,
  input  logic [YW-1:0]            player_y,
  input  logic [N_OBJ*XW-1:0]      obj_x,
  input  logic [N_OBJ*YW-1:0]      obj_y,
  input  logic [N_OBJ*XW-1:0]      obj_w,
  input  logic [N_OBJ*YW-1:0]      obj_h,
  input  logic [N_OBJ-1:0]         obj_active,
  output logic [N_OBJ-1:0]         hit_mask,
  output logic                     hit_any,
  output logic [$clog2(N_OBJ)-1:0] hit_idx,
  output logic                     scan_done,
  output logic                     over
);

  localparam int unsigned IW = $clog2(N_OBJ);
  localparam int unsigned XE = XW + 1;
  localparam int unsigned YE = YW + 1;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_OBJ-1:0]  scratch_q, scratch_d;
  logic [XW-1:0]     px_q, px_d;
  logic [YW-1:0]     py_q, py_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_OBJ-1:0]  hit_mask_q, hit_mask_d;
  logic              hit_any_q, hit_any_d;
  logic [IW-1:0]     hit_idx_q, hit_idx_d;
  logic              scan_done_q, scan_done_d;
  logic              over_q, over_d;

  logic [XW-1:0]     cur_x, cur_w;
  logic [YW-1:0]     cur_y, cur_h;
  logic              cur_act;
  logic              hit_c;
  logic [IW-1:0]     first_idx;
  logic [CW-1:0]     cnt_inc;

  // Select the live geometry of the slot under evaluation.
  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_w   = '0;
    cur_h   = '0;
    cur_act = 1'b0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      if (idx_q == IW'(i)) begin
        cur_x   = obj_x[i*XW +: XW];
        cur_y   = obj_y[i*YW +: YW];
        cur_w   = obj_w[i*XW +: XW];
        cur_h   = obj_h[i*YW +: YW];
        cur_act = obj_active[i];
      end
    end
  end

  // Strict overlap against the snapshot, one extra bit so sums never wrap.
  logic x_lo_ok, x_hi_ok, y_lo_ok, y_hi_ok;
  always_comb begin
    x_lo_ok = XE'(cur_x) < (XE'(px_q) + XE'(PLAYER_W));
    x_hi_ok = (XE'(cur_x) + XE'(cur_w)) > XE'(px_q);
    y_lo_ok = YE'(cur_y) < (YE'(py_q) + YE'(PLAYER_H));
    y_hi_ok = (YE'(cur_y) + YE'(cur_h)) > YE'(py_q);
    hit_c   = cur_act & x_lo_ok & x_hi_ok & y_lo_ok & y_hi_ok;
  end

  // Lowest set slot of the completed scratch mask.
  always_comb begin
    first_idx = '0;
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (scratch_q[i]) first_idx = IW'(i);
    end
  end

  assign cnt_inc = (cnt_q >= CW'(HIT_CNT)) ? CW'(HIT_CNT) : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scratch_d   = scratch_q;
    px_d        = px_q;
    py_d        = py_q;
    cnt_d       = cnt_q;
    hit_mask_d  = hit_mask_q;
    hit_any_d   = hit_any_q;
    hit_idx_d   = hit_idx_q;
    scan_done_d = 1'b0;
    over_d      = over_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_SCAN;
          px_d      = player_x;
          py_d      = player_y;
          idx_d     = '0;
          scratch_d = '0;
        end
      end

      ST_SCAN: begin
        if (!enable) begin
          // Abort: discard the partial scan and break the hit streak.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          scratch_d[idx_q] = hit_c;
          if (idx_q == IW'(N_OBJ - 1)) state_d = ST_COMMIT;
          else                         idx_d   = idx_q + IW'(1);
        end
      end

      ST_COMMIT: begin
        hit_mask_d  = scratch_q;
        hit_any_d   = |scratch_q;
        hit_idx_d   = first_idx;
        scan_done_d = 1'b1;
        cnt_d       = (|scratch_q) ? cnt_inc : '0;
        if (cnt_d == CW'(HIT_CNT)) over_d = 1'b1;
`ifdef HAZARD_ZONE_EN
        if ((32'(px_q) < ZONE_X) && (32'(py_q) < ZONE_Y)) over_d = 1'b1;
`endif
        if (enable) begin
          state_d   = ST_SCAN;
          px_d      = player_x;
          py_d      = player_y;
          idx_d     = '0;
          scratch_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Clear overrides everything, including a commit in the same cycle.
    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      hit_mask_d  = '0;
      hit_any_d   = 1'b0;
      hit_idx_d   = '0;
      scan_done_d = 1'b0;
      over_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      scratch_q   <= '0;
      px_q        <= '0;
      py_q        <= '0;
      cnt_q       <= '0;
      hit_mask_q  <= '0;
      hit_any_q   <= 1'b0;
      hit_idx_q   <= '0;
      scan_done_q <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scratch_q   <= scratch_d;
      px_q        <= px_d;
      py_q        <= py_d;
      cnt_q       <= cnt_d;
      hit_mask_q  <= hit_mask_d;
      hit_any_q   <= hit_any_d;
      hit_idx_q   <= hit_idx_d;
      scan_done_q <= scan_done_d;
      over_q      <= over_d;
    end
  end

  assign hit_mask  = hit_mask_q;
  assign hit_any   = hit_any_q;
  assign hit_idx   = hit_idx_q;
  assign scan_done = scan_done_q;
  assign over      = over_q;

endmodule
